// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer widths and counting helper
package rob_pkg;

  localparam int ROB_IDX_W_DEF = 7;
  localparam int REG_ID_W_DEF  = 5;
  localparam int ALLOC_W_DEF   = 4;
  localparam int CMPL_W_DEF    = 2;
  localparam int RETIRE_W_DEF  = 4;

  // Bits needed to hold a count of 0..n inclusive
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rob_prefix_popcount.sv
// rtl/rob_prefix_popcount.sv - exclusive prefix popcount with total
module rob_prefix_popcount
  import rob_pkg::*;
#(
  parameter int N = ALLOC_W_DEF,
  parameter int W = cnt_w(N)
) (
  input  logic [N-1:0]        bits_i,
  output logic [N-1:0][W-1:0] prefix_o,
  output logic [W-1:0]        total_o
);

  // Lane k sees the number of set bits strictly below it
  always_comb begin
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++) begin
      prefix_o[k] = acc;
      acc = acc + W'(bits_i[k]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - multi-issue reorder buffer with in-order retire
module rob_multiport
  import rob_pkg::*;
#(
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int REG_ID_W  = REG_ID_W_DEF,
  parameter int ALLOC_W   = ALLOC_W_DEF,
  parameter int CMPL_W    = CMPL_W_DEF,
  parameter int RETIRE_W  = RETIRE_W_DEF
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic [ALLOC_W-1:0]            alloc_valid_i,
  input  logic [ALLOC_W-1:0]            alloc_destEn_i,
  input  logic [ALLOC_W*REG_ID_W-1:0]   alloc_destReg_i,
  output logic                          alloc_ready_o,
  output logic [ALLOC_W*ROB_IDX_W-1:0]  alloc_idx_o,
  input  logic [CMPL_W-1:0]             cmpl_valid_i,
  input  logic [CMPL_W*ROB_IDX_W-1:0]   cmpl_idx_i,
  output logic [RETIRE_W-1:0]           retire_valid_o,
  output logic [RETIRE_W-1:0]           retire_destEn_o,
  output logic [RETIRE_W*REG_ID_W-1:0]  retire_destReg_o,
  output logic [RETIRE_W*ROB_IDX_W-1:0] retire_idx_o,
  output logic [ROB_IDX_W-1:0]          head_o,
  output logic [ROB_IDX_W-1:0]          tail_o,
  output logic [ROB_IDX_W:0]            count_o,
  output logic                          isEmpty_o,
  output logic                          isFull_o
);

  localparam int DEPTH = 2 ** ROB_IDX_W;
  localparam int CNT_W = ROB_IDX_W + 1;
  localparam int AW    = cnt_w(ALLOC_W);

  logic [DEPTH-1:0]               valid_q, valid_d;
  logic [DEPTH-1:0]               cmpl_q, cmpl_d;
  logic [DEPTH-1:0]               dest_en_q;
  logic [DEPTH-1:0][REG_ID_W-1:0] dest_reg_q;
  logic [ROB_IDX_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]               count_q, count_d;

  logic [ALLOC_W-1:0][AW-1:0]        alloc_off;
  logic [AW-1:0]                     alloc_total;
  logic                              alloc_fire;
  logic [ALLOC_W-1:0][ROB_IDX_W-1:0] alloc_idx;
  logic [RETIRE_W-1:0]               ret_valid;
  logic [CNT_W-1:0]                  n_alloc, n_retire;

  rob_prefix_popcount #(.N(ALLOC_W), .W(AW)) u_alloc_pc (
    .bits_i   (alloc_valid_i),
    .prefix_o (alloc_off),
    .total_o  (alloc_total)
  );

  // Free space is judged on the current count only; flush cancels the allocation
  assign alloc_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ALLOC_W);
  assign alloc_fire    = alloc_ready_o & ~flush_i;
  assign n_alloc       = alloc_fire ? CNT_W'(alloc_total) : '0;

  // Compact valid lanes onto consecutive slots starting at the tail
  always_comb begin
    alloc_idx   = '0;
    alloc_idx_o = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_idx[k] = tail_q + ROB_IDX_W'(alloc_off[k]);
      alloc_idx_o[k*ROB_IDX_W +: ROB_IDX_W] = alloc_idx[k];
    end
  end

  // In-order retire window: AND-prefix of valid&completed from the head
  always_comb begin
    logic                 run;
    logic [ROB_IDX_W-1:0] ridx;
    run              = ~flush_i;
    n_retire         = '0;
    ret_valid        = '0;
    retire_idx_o     = '0;
    retire_destEn_o  = '0;
    retire_destReg_o = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      ridx = head_q + ROB_IDX_W'(k);
      run  = run & valid_q[ridx] & cmpl_q[ridx] & (CNT_W'(k) < count_q);
      ret_valid[k] = run;
      n_retire     = n_retire + CNT_W'(run);
      retire_idx_o[k*ROB_IDX_W +: ROB_IDX_W]  = ridx;
      retire_destEn_o[k]                      = dest_en_q[ridx];
      retire_destReg_o[k*REG_ID_W +: REG_ID_W] = dest_reg_q[ridx];
    end
  end

  assign retire_valid_o = ret_valid;

  // Entry status update: completions, then retire clears, then allocation wins
  always_comb begin
    logic [ROB_IDX_W-1:0] cidx;
    valid_d = valid_q;
    cmpl_d  = cmpl_q;
    cidx    = '0;
    for (int p = 0; p < CMPL_W; p++) begin
      cidx = cmpl_idx_i[p*ROB_IDX_W +: ROB_IDX_W];
      if (cmpl_valid_i[p] && valid_q[cidx]) cmpl_d[cidx] = 1'b1;
    end
    for (int k = 0; k < RETIRE_W; k++) begin
      if (ret_valid[k]) begin
        valid_d[head_q + ROB_IDX_W'(k)] = 1'b0;
        cmpl_d[head_q + ROB_IDX_W'(k)]  = 1'b0;
      end
    end
    for (int k = 0; k < ALLOC_W; k++) begin
      if (alloc_fire && alloc_valid_i[k]) begin
        valid_d[alloc_idx[k]] = 1'b1;
        cmpl_d[alloc_idx[k]]  = 1'b0;
      end
    end
    if (flush_i) begin
      valid_d = '0;
      cmpl_d  = '0;
    end
  end

  // Pointer and occupancy next state; flush returns everything to zero
  always_comb begin
    head_d  = flush_i ? '0 : head_q + ROB_IDX_W'(n_retire);
    tail_d  = flush_i ? '0 : tail_q + ROB_IDX_W'(n_alloc);
    count_d = flush_i ? '0 : count_q + n_alloc - n_retire;
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= '0;
      cmpl_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      cmpl_q  <= cmpl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage, only meaningful while the entry is valid
  always_ff @(posedge clock_i) begin
    for (int k = 0; k < ALLOC_W; k++) begin
      if (alloc_fire && alloc_valid_i[k]) begin
        dest_en_q[alloc_idx[k]]  <= alloc_destEn_i[k];
        dest_reg_q[alloc_idx[k]] <= alloc_destReg_i[k*REG_ID_W +: REG_ID_W];
      end
    end
  end

  assign head_o    = head_q;
  assign tail_o    = tail_q;
  assign count_o   = count_q;
  assign isEmpty_o = (count_q == '0);
  assign isFull_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_rob_multiport.sv
// tb/tb_rob_multiport.sv - scoreboard bench for rob_multiport
module tb_rob_multiport;

  localparam int IW = 7;
  localparam int RW = 5;
  localparam int AW = 4;
  localparam int CW = 2;
  localparam int TW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush;
  logic [AW-1:0]    alloc_valid, alloc_en;
  logic [AW*RW-1:0] alloc_reg;
  logic             ready;
  logic [AW*IW-1:0] alloc_idx;
  logic [CW-1:0]    cmpl_valid;
  logic [CW*IW-1:0] cmpl_idx;
  logic [TW-1:0]    retire_valid, retire_en;
  logic [TW*RW-1:0] retire_reg;
  logic [TW*IW-1:0] retire_idx;
  logic [IW-1:0]    head, tail;
  logic [IW:0]      count;
  logic             is_empty, is_full;

  typedef struct {
    int idx;
    bit en;
    int reg_id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_tail = 0;
  int   seq = 0;

  rob_multiport dut (
    .clock_i          (clk),
    .reset_i          (rst_n),
    .flush_i          (flush),
    .alloc_valid_i    (alloc_valid),
    .alloc_destEn_i   (alloc_en),
    .alloc_destReg_i  (alloc_reg),
    .alloc_ready_o    (ready),
    .alloc_idx_o      (alloc_idx),
    .cmpl_valid_i     (cmpl_valid),
    .cmpl_idx_i       (cmpl_idx),
    .retire_valid_o   (retire_valid),
    .retire_destEn_o  (retire_en),
    .retire_destReg_o (retire_reg),
    .retire_idx_o     (retire_idx),
    .head_o           (head),
    .tail_o           (tail),
    .count_o          (count),
    .isEmpty_o        (is_empty),
    .isFull_o         (is_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int lane_idx(input int k);
    return int'(alloc_idx[k*IW +: IW]);
  endfunction

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = '0;
    alloc_en    = '0;
    alloc_reg   = '0;
    cmpl_valid  = '0;
    cmpl_idx    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  // Present an allocation; when acc is set the entries are expected to retire later
  task automatic alloc(input logic [3:0] m, input bit acc);
    int   off;
    int   r;
    bit   en;
    exp_t e;
    off = 0;
    alloc_valid = m;
    for (int k = 0; k < AW; k++) begin
      r  = (seq * 5 + k * 3 + 1) % 32;
      en = ((seq + k) % 3) != 0;
      alloc_en[k] = en;
      alloc_reg[k*RW +: RW] = 5'(r);
      if (m[k] && acc) begin
        e.idx    = (m_tail + off) % 128;
        e.en     = en;
        e.reg_id = r;
        exp_q.push_back(e);
        off++;
      end
    end
    if (acc) m_tail = (m_tail + off) % 128;
    seq++;
  endtask

  task automatic cmpl(input bit v0, input int i0, input bit v1, input int i1);
    cmpl_valid = {v1, v0};
    cmpl_idx   = {7'(i1), 7'(i0)};
  endtask

  // Monitor: every retiring lane must match the next entry in program order
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < TW; k++) begin
        if (retire_valid[k]) begin
          if (k > 0) begin
            n_checks++;
            if (!retire_valid[k-1]) begin
              n_fail++;
              $display("FAIL retire_contig: lane %0d valid with lane %0d idle, got %b", k, k - 1, retire_valid);
            end
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL retire_unexpected: got idx %0d on lane %0d, required no retirement", int'(retire_idx[k*IW +: IW]), k);
          end else begin
            e = exp_q.pop_front();
            if (int'(retire_idx[k*IW +: IW]) != e.idx || retire_en[k] != e.en ||
                int'(retire_reg[k*RW +: RW]) != e.reg_id) begin
              n_fail++;
              $display("FAIL retire_entry lane %0d: got idx %0d en %0d reg %0d, required idx %0d en %0d reg %0d",
                       k, int'(retire_idx[k*IW +: IW]), retire_en[k], int'(retire_reg[k*RW +: RW]),
                       e.idx, e.en, e.reg_id);
            end
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    chk("rst_count", int'(count), 0);
    chk("rst_head", int'(head), 0);
    chk("rst_tail", int'(tail), 0);
    chk("rst_empty", int'(is_empty), 1);
    chk("rst_full", int'(is_full), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_retire", int'(retire_valid), 0);

    // Asynchronous reset in the middle of a cycle with five entries live
    alloc(4'b1111, 1'b1);
    tick();
    alloc(4'b0100, 1'b1);
    tick();
    settle();
    chk("a_count", int'(count), 5);
    chk("a_tail", int'(tail), 5);
    cmpl(1'b1, 0, 1'b1, 1);
    tick();
    settle();
    chk("a_pre_retire", int'(retire_valid), 4'b0011);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_tail = 0;
    chk("a_rst_count", int'(count), 0);
    chk("a_rst_head", int'(head), 0);
    chk("a_rst_tail", int'(tail), 0);
    chk("a_rst_empty", int'(is_empty), 1);
    chk("a_rst_retire", int'(retire_valid), 0);
    chk("a_rst_ready", int'(ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();

    // Out-of-order completion, in-order retirement
    alloc(4'b1111, 1'b1);
    settle();
    chk("c_idx0", lane_idx(0), 0);
    chk("c_idx3", lane_idx(3), 3);
    tick();
    cmpl(1'b1, 2, 1'b1, 0);
    tick();
    settle();
    chk("c_ret_first", int'(retire_valid), 4'b0001);
    cmpl(1'b1, 1, 1'b1, 3);
    tick();
    settle();
    chk("c_ret_second", int'(retire_valid), 4'b0111);
    chk("c_head1", int'(head), 1);
    chk("c_count3", int'(count), 3);
    tick();
    settle();
    chk("c_head4", int'(head), 4);
    chk("c_empty", int'(is_empty), 1);

    // Completion of an invalid entry is ignored; duplicate ports are idempotent
    cmpl(1'b1, 4, 1'b1, 4);
    tick();
    alloc(4'b1111, 1'b1);
    tick();
    settle();
    chk("inv_cmpl_ignored", int'(retire_valid), 0);
    cmpl(1'b1, 4, 1'b1, 4);
    tick();
    settle();
    chk("dup_cmpl", int'(retire_valid), 4'b0001);
    cmpl(1'b1, 5, 1'b1, 6);
    tick();
    settle();
    chk("cmpl_5_6", int'(retire_valid), 4'b0011);
    cmpl(1'b1, 7, 1'b0, 0);
    tick();
    settle();
    chk("cmpl_7", int'(retire_valid), 4'b0001);
    tick();
    settle();
    chk("d_head8", int'(head), 8);
    chk("d_tail8", int'(tail), 8);

    // Allocation beats a same-cycle completion to the same slot
    alloc(4'b1111, 1'b1);
    cmpl(1'b1, 8, 1'b1, 9);
    tick();
    settle();
    chk("alloc_wins", int'(retire_valid), 0);

    // Fill to 125: request dropped, retire 3, ready only on the cycle after
    for (int i = 0; i < 30; i++) begin
      alloc(4'b1111, 1'b1);
      tick();
    end
    alloc(4'b0001, 1'b1);
    tick();
    settle();
    chk("f_count125", int'(count), 125);
    chk("f_ready0", int'(ready), 0);
    chk("f_tail5", int'(tail), 5);
    alloc(4'b1111, 1'b0);
    cmpl(1'b1, 10, 1'b1, 9);
    tick();
    settle();
    chk("f_drop_tail", int'(tail), 5);
    alloc(4'b1111, 1'b0);
    cmpl(1'b1, 8, 1'b0, 0);
    settle();
    chk("f_ret_blocked", int'(retire_valid), 0);
    tick();
    settle();
    chk("f_ret3", int'(retire_valid), 4'b0111);
    chk("f_ready_still0", int'(ready), 0);
    alloc(4'b1111, 1'b0);
    tick();
    settle();
    chk("f_count122", int'(count), 122);
    chk("f_tail_kept", int'(tail), 5);
    chk("f_head11", int'(head), 11);
    chk("f_ready1", int'(ready), 1);

    // Fill to full, then retire four at once
    alloc(4'b0011, 1'b1);
    tick();
    alloc(4'b1111, 1'b1);
    settle();
    chk("g_ready_at124", int'(ready), 1);
    tick();
    settle();
    chk("g_full", int'(is_full), 1);
    chk("g_count128", int'(count), 128);
    chk("g_ready0", int'(ready), 0);
    chk("g_tail11", int'(tail), 11);
    cmpl(1'b1, 14, 1'b1, 13);
    tick();
    cmpl(1'b1, 12, 1'b1, 11);
    tick();
    settle();
    chk("g_ret4_full", int'(retire_valid), 4'b1111);
    tick();
    settle();
    chk("g_count124", int'(count), 124);
    cmpl(1'b1, 18, 1'b1, 17);
    tick();
    cmpl(1'b1, 16, 1'b1, 15);
    tick();
    settle();
    chk("g_ret4", int'(retire_valid), 4'b1111);
    chk("g_ready124", int'(ready), 1);
    alloc(4'b1111, 1'b1);
    settle();
    chk("g_alloc_idx0", lane_idx(0), 11);
    tick();
    settle();
    chk("g_count_same", int'(count), 124);
    chk("g_head19", int'(head), 19);
    chk("g_tail15", int'(tail), 15);

    // Flush a full-ish buffer, then flush 10 entries with concurrent activity
    flush = 1'b1;
    tick();
    exp_q.delete();
    m_tail = 0;
    settle();
    chk("h_count0", int'(count), 0);
    alloc(4'b1111, 1'b1);
    tick();
    alloc(4'b1111, 1'b1);
    tick();
    alloc(4'b0011, 1'b1);
    tick();
    settle();
    chk("h_count10", int'(count), 10);
    cmpl(1'b1, 0, 1'b1, 1);
    tick();
    settle();
    chk("h_pre_flush_ret", int'(retire_valid), 4'b0011);
    flush = 1'b1;
    alloc(4'b1111, 1'b0);
    cmpl(1'b1, 2, 1'b1, 3);
    settle();
    chk("h_flush_ret0", int'(retire_valid), 0);
    tick();
    exp_q.delete();
    m_tail = 0;
    settle();
    chk("h_count", int'(count), 0);
    chk("h_head", int'(head), 0);
    chk("h_tail", int'(tail), 0);
    chk("h_empty", int'(is_empty), 1);
    chk("h_retire", int'(retire_valid), 0);
    alloc(4'b1111, 1'b1);
    tick();
    settle();
    chk("h_cmpl_cleared", int'(retire_valid), 0);

    // Walk the pointers round to 126 and drain
    for (int i = 0; i < 30; i++) begin
      alloc(4'b1111, 1'b1);
      tick();
    end
    alloc(4'b0011, 1'b1);
    tick();
    settle();
    chk("w_tail126", int'(tail), 126);
    for (int i = 0; i < 63; i++) begin
      cmpl(1'b1, 2 * i, 1'b1, 2 * i + 1);
      tick();
    end
    repeat (3) tick();
    settle();
    chk("w_empty", int'(is_empty), 1);
    chk("w_head126", int'(head), 126);

    // Sparse lanes across the wrap point
    alloc(4'b1011, 1'b1);
    settle();
    chk("b_idx_lane0", lane_idx(0), 126);
    chk("b_idx_lane1", lane_idx(1), 127);
    chk("b_idx_lane3", lane_idx(3), 0);
    tick();
    settle();
    chk("b_tail1", int'(tail), 1);
    chk("b_count3", int'(count), 3);
    cmpl(1'b1, 126, 1'b1, 127);
    tick();
    cmpl(1'b1, 0, 1'b0, 0);
    tick();
    repeat (2) tick();
    settle();
    chk("b_empty", int'(is_empty), 1);
    chk("b_head1", int'(head), 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised multi-issue reorder buffer: a circular queue of DEPTH entries.
- Allocates up to ALLOC_W instructions per cycle at the tail, in program order.
- Marks entries completed out of order via CMPL_W writeback ports.
- Retires up to RETIRE_W contiguous completed entries per cycle from the head, in order.
- Sits between dispatch/rename and the OoO execution pipes; supports full pipeline flush.

Parameters:
- ROB_IDX_W, 7, entry index width; DEPTH = 2**ROB_IDX_W (power of two required).
- REG_ID_W, 5, architectural destination register id width.
- ALLOC_W, 4, allocation lanes per cycle.
- CMPL_W, 2, completion writeback ports.
- RETIRE_W, 4, maximum retirements per cycle (RETIRE_W <= DEPTH).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; discards all entries.
- alloc_valid_i  in  ALLOC_W  per-lane allocation request; lane 0 is oldest.
- alloc_destEn_i  in  ALLOC_W  lane writes a destination register.
- alloc_destReg_i  in  ALLOC_W*REG_ID_W  destination id per lane; lane k occupies bits [k*REG_ID_W +: REG_ID_W].
- alloc_ready_o  out  1  high when free entries >= ALLOC_W.
- alloc_idx_o  out  ALLOC_W*ROB_IDX_W  ROB index assigned to each valid lane (combinational).
- cmpl_valid_i  in  CMPL_W  completion strobe per port.
- cmpl_idx_i  in  CMPL_W*ROB_IDX_W  index being completed.
- retire_valid_o  out  RETIRE_W  retiring lanes; always a contiguous prefix starting at lane 0.
- retire_destEn_o  out  RETIRE_W  destEn of each retiring entry.
- retire_destReg_o  out  RETIRE_W*REG_ID_W  destReg of each retiring entry.
- retire_idx_o  out  RETIRE_W*ROB_IDX_W  index of each retiring entry.
- head_o  out  ROB_IDX_W  oldest entry index.
- tail_o  out  ROB_IDX_W  next free index.
- count_o  out  ROB_IDX_W+1  occupied entries, 0..DEPTH.
- isEmpty_o, isFull_o  out  1  count_o==0 / count_o==DEPTH.

Behaviour:
- Per-entry state: valid, completed, destEn, destReg.
- Reset (reset_i low, asynchronous) and flush (flush_i high at a clock edge) produce the same state:
  - all valid/completed bits cleared; head=tail=count=0;
  - isEmpty_o=1, isFull_o=0, alloc_ready_o=1, retire_valid_o=0.
- Flush priority: flush beats same-cycle alloc, completion and retire. retire_valid_o is forced to 0 while flush_i=1.
- Allocation:
  - Accepted only when alloc_ready_o=1. If alloc_ready_o=0 the request is dropped with no state change; the producer must hold its request.
  - alloc_ready_o is computed from the current count (DEPTH-count >= ALLOC_W). Same-cycle retirements do not count toward free space.
  - Valid lanes are compacted in order: lane k gets index (tail + popcount(alloc_valid_i[0..k-1])) mod DEPTH.
  - At the edge, each allocated entry is written with valid=1, completed=0, destEn, destReg.
  - tail advances by nAlloc, modulo DEPTH (wrap-around).
  - alloc_idx_o for invalid lanes is don't-care.
- Completion:
  - At the edge, completed[cmpl_idx]=1 for each valid port whose target entry is valid.
  - Completion of an invalid entry is ignored.
  - Duplicate indices across ports are legal (idempotent).
  - Completion to an index being allocated in the same cycle is illegal; allocation wins (completed=0).
- Retirement:
  - Combinational from current state: lane k is valid iff entries head..head+k (mod DEPTH) are all valid and completed, and k < count.
  - At the edge: retired entries have valid and completed cleared; head advances by nRetire.
  - Retirement is unconditional (no backpressure).
  - Minimum latency: completion strobe at edge t, retire_valid_o visible during cycle t+1, head advances at edge t+1.
- Count: count_next = count + nAlloc - nRetire. Simultaneous alloc and retire is allowed, including when full (retire only) or empty (alloc only).
- Wrap: head, tail and compaction arithmetic are all modulo DEPTH. Full is distinguished from empty by count, never by comparing head to tail.

Decomposition:
- Shared package rob_pkg: default ROB_IDX_W/REG_ID_W and entry field widths. The same constants are used by the dispatch and writeback blocks.
- One sub-module, rob_prefix_popcount (parametrised N): exclusive prefix popcount plus total. It is instantiated for allocation compaction (N=ALLOC_W). Retirement uses an AND-prefix over the completed bits.

Test Plan:
- Reset low mid-run with count=5 -> asynchronously head=tail=count=0, isEmpty_o=1, retire_valid_o=0, alloc_ready_o=1.
- Alloc valid=4'b1011 at tail=126 (DEPTH=128) -> alloc_idx lanes 0,1,3 = 126,127,0; tail=1; count=3.
- Allocate idx 0..3, complete 2 then 0 -> retire lane 0 only (idx 0). Then complete 1 and 3 -> next cycle retire_valid_o=4'b0111 (idx 1,2,3); head=4; isEmpty_o=1.
- Fill to count=125 -> alloc_ready_o=0, a 4-lane request is dropped, tail unchanged. Retire 3 entries -> alloc_ready_o=1 the following cycle.
- Fill to 128 -> isFull_o=1. Same cycle: allocate 4 and retire 4 when count=124 -> count stays 124.
- flush_i with 10 entries, concurrent alloc and completion -> next cycle count=0, head=tail=0, all completed bits clear, retire_valid_o=0.
